xbox_row_mover: RTL and testbench

XBOX_ROW_MOVER -- requirements
Module: xbox_row_mover

---
 rtl/xbox_row_mover_if.sv | 39 +++
 rtl/xbox_row_mover.sv | 120 ++++++++++++
 tb/tb_xbox_row_mover.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/xbox_row_mover_if.sv
// Bundle of the request, XBOX-memory and register-file signals of the row mover.
// The slave modport is the mover; the master modport is whatever drives requests
// and answers the memory / RF reads.
interface xbox_row_mover_if;
    // Request channel
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [13:0]   req_addr;
    logic [1:0]    req_vec;
    // XBOX memory side
    logic          mem_rd;
    logic          mem_wr;
    logic [13:0]   mem_addr;
    logic [1023:0] mem_wdata;
    logic [1023:0] mem_rdata;
    // Register-file side
    logic          rf_we;
    logic          rf_re;
    logic [1:0]    rf_vec;
    logic [4:0]    rf_idx;
    logic [31:0]   rf_wdata;
    logic [31:0]   rf_rdata;
    // Status
    logic          done;
    logic          err;

    modport master (
        output req_valid, req_write, req_addr, req_vec, mem_rdata, rf_rdata,
        input  req_ready, mem_rd, mem_wr, mem_addr, mem_wdata,
               rf_we, rf_re, rf_vec, rf_idx, rf_wdata, done, err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_vec, mem_rdata, rf_rdata,
        output req_ready, mem_rd, mem_wr, mem_addr, mem_wdata,
               rf_we, rf_re, rf_vec, rf_idx, rf_wdata, done, err
    );
endinterface

// File: rtl/xbox_row_mover.sv
// xbox_row_mover: moves one 1024-bit XBOX row into a 32 x 32-bit RF vector (load)
// or assembles an RF vector into one row write (store). Word i of a row is
// bits [32i+31:32i]. Load reads wait RD_LAT cycles for mem_rdata.
module xbox_row_mover #(
    parameter int RD_LAT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    xbox_row_mover_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD_WAIT, UNPACK, GATHER, WRITE, FIN} state_e;

    localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);
    localparam logic [1:0] VEC_RSVD = 2'd3;

    state_e        state_q, state_d;
    logic [3:0]    lat_q, lat_d;
    logic [4:0]    word_q, word_d;
    logic [1023:0] row_q, row_d;
    logic [13:0]   addr_q, addr_d;
    logic [1:0]    vec_q, vec_d;
    logic          err_q, err_d;
    logic [9:0]    word_lsb;
    logic          rf_we, rf_re;

    assign word_lsb = {word_q, 5'd0};

    // Next-state logic: sequencing, counters and row-buffer updates.
    always_comb begin
        // NOTE: every target gets a default before the case so no path can leave
        // a variable unassigned and infer a latch.
        state_d = state_q;
        lat_d   = lat_q;
        word_d  = word_q;
        row_d   = row_q;
        addr_d  = addr_q;
        vec_d   = vec_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d = bus.req_addr;
                    vec_d  = bus.req_vec;
                    // The transfer direction is carried by which branch of the
                    // state graph is taken, so it needs no register of its own.
                    if (bus.req_vec == VEC_RSVD) begin
                        err_d = 1'b1;
                    end else if (bus.req_write) begin
                        state_d = GATHER;
                    end else begin
                        state_d = RD_WAIT;
                        lat_d   = 4'd0;
                    end
                end
            end
            RD_WAIT: begin
                // lat_q counts cycles since the read strobe; data lands RD_LAT later.
                if (lat_q == RD_LAT_C) begin
                    row_d   = bus.mem_rdata;
                    lat_d   = 4'd0;
                    state_d = UNPACK;
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end
            UNPACK: begin
                word_d = word_q + 5'd1;
                if (word_q == 5'd31) state_d = FIN;
            end
            GATHER: begin
                row_d[word_lsb +: 32] = bus.rf_rdata;
                word_d                = word_q + 5'd1;
                if (word_q == 5'd31) state_d = WRITE;
            end
            WRITE:   state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counter and buffer registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lat_q   <= '0;
            word_q  <= '0;
            // NOTE: the row buffer is cleared on reset so an aborted transfer
            // leaves no stale row data behind.
            row_q   <= '0;
            addr_q  <= '0;
            vec_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q <= state_d;
            lat_q   <= lat_d;
            word_q  <= word_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode only registered state, so no input reaches an output combinationally.
    assign rf_we         = (state_q == UNPACK);
    assign rf_re         = (state_q == GATHER);
    assign bus.req_ready = (state_q == IDLE);
    assign bus.mem_rd    = (state_q == RD_WAIT) && (lat_q == 4'd0);
    assign bus.mem_wr    = (state_q == WRITE);
    assign bus.mem_addr  = (state_q == IDLE) ? '0 : addr_q;
    assign bus.mem_wdata = (state_q == WRITE) ? row_q : '0;
    assign bus.rf_we     = rf_we;
    assign bus.rf_re     = rf_re;
    assign bus.rf_vec    = (rf_we || rf_re) ? vec_q : '0;
    assign bus.rf_idx    = (rf_we || rf_re) ? word_q : '0;
    assign bus.rf_wdata  = rf_we ? row_q[word_lsb +: 32] : '0;
    assign bus.done      = (state_q == FIN);
    assign bus.err       = err_q;
endmodule

// File: tb/tb_xbox_row_mover.sv
// Directed bench for xbox_row_mover: three instances (RD_LAT 2, 1, 15) share one
// request stream; per-instance monitors tally activity for the directed checks.
module tb_xbox_row_mover;
    logic          clk = 1'b0;
    logic          rst_n;
    int            cyc = 0;
    logic          clr;
    int            t0;
    logic [13:0]   exp_addr;
    logic [1:0]    exp_vec;
    logic          req_valid, req_write;
    logic [13:0]   req_addr;
    logic [1:0]    req_vec;
    logic [1023:0] row_pat, row_junk, store_pat;
    int            vecs = 0;
    int            miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
        xbox_row_mover_if bus ();
        int rd_cyc = -100;
        int n_rd, rd_at, n_wr, wr_at, wr_bad, n_we, we_first, we_last, we_bad;
        int n_re, re_first, re_bad, n_done, done_at, n_err, err_at, n_busy, bad_misc;
        logic [13:0] rd_addr, wr_addr;

        assign bus.req_valid = req_valid;
        assign bus.req_write = req_write;
        assign bus.req_addr  = req_addr;
        assign bus.req_vec   = req_vec;
        // Row data is only valid exactly LAT cycles after the read strobe.
        assign bus.mem_rdata = (cyc == rd_cyc + LAT) ? row_pat : row_junk;
        assign bus.rf_rdata  = bus.rf_re ? (32'h100 + {27'd0, bus.rf_idx}) : 32'hBAD0_BAD0;

        xbox_row_mover #(.RD_LAT(LAT)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

        always @(negedge clk) if (bus.mem_rd) rd_cyc <= cyc;

        always @(negedge clk) begin
            if (clr) begin
                n_rd <= 0; rd_at <= 0; n_wr <= 0; wr_at <= 0; wr_bad <= 0;
                n_we <= 0; we_first <= 0; we_last <= 0; we_bad <= 0;
                n_re <= 0; re_first <= 0; re_bad <= 0; n_done <= 0; done_at <= 0;
                n_err <= 0; err_at <= 0; n_busy <= 0; bad_misc <= 0;
                rd_addr <= '0; wr_addr <= '0;
            end else begin
                if (bus.mem_rd) begin
                    n_rd <= n_rd + 1; rd_at <= cyc - t0; rd_addr <= bus.mem_addr;
                end
                if (bus.mem_wr) begin
                    n_wr <= n_wr + 1; wr_at <= cyc - t0; wr_addr <= bus.mem_addr;
                    wr_bad <= wr_bad + int'(bus.mem_wdata != store_pat);
                end
                if (bus.rf_we) begin
                    n_we <= n_we + 1; we_last <= cyc - t0;
                    if (n_we == 0) we_first <= cyc - t0;
                    we_bad <= we_bad + int'(bus.rf_idx != 5'(n_we) || bus.rf_vec != exp_vec ||
                              bus.rf_wdata != (32'hA500_0000 + {27'd0, bus.rf_idx}));
                end
                if (bus.rf_re) begin
                    n_re <= n_re + 1;
                    if (n_re == 0) re_first <= cyc - t0;
                    re_bad <= re_bad + int'(bus.rf_idx != 5'(n_re) || bus.rf_vec != exp_vec);
                end
                if (bus.done) begin n_done <= n_done + 1; done_at <= cyc - t0; end
                if (bus.err)  begin n_err <= n_err + 1; err_at <= cyc - t0; end
                if (!bus.req_ready) n_busy <= n_busy + 1;
                if ((bus.mem_rd && bus.mem_wr) || (bus.rf_we && bus.rf_re) ||
                    (!bus.mem_wr && bus.mem_wdata != '0) || (!bus.rf_we && bus.rf_wdata != '0) ||
                    (!(bus.rf_we || bus.rf_re) && bus.rf_vec != 2'd0) ||
                    (bus.req_ready && bus.mem_addr != 14'd0) ||
                    (!bus.req_ready && bus.mem_addr != exp_addr))
                    bad_misc <= bad_misc + 1;
            end
        end
    end

    task automatic check(input string tag, input int obs, input int expv);
        vecs++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a request for one cycle and restart the monitors with it as cycle T.
    task automatic issue(input logic w, input logic [13:0] a, input logic [1:0] v);
        clr = 1'b1; t0 = cyc; exp_addr = a; exp_vec = v;
        req_valid = 1'b1; req_write = w; req_addr = a; req_vec = v;
        step();
        clr = 1'b0; req_valid = 1'b0;
    endtask

    function automatic int ctl0();
        return int'({19'd0, g_dut[0].bus.mem_rd, g_dut[0].bus.mem_wr, g_dut[0].bus.rf_we,
                     g_dut[0].bus.rf_re, g_dut[0].bus.rf_vec, g_dut[0].bus.rf_idx,
                     g_dut[0].bus.done, g_dut[0].bus.err});
    endfunction

    task automatic check_idle0(input string tag);
        check({tag, "_ready"}, int'(g_dut[0].bus.req_ready), 1);
        check({tag, "_ctl"}, ctl0(), 0);
        check({tag, "_addr"}, int'(g_dut[0].bus.mem_addr), 0);
        check({tag, "_rf_wdata"}, int'(g_dut[0].bus.rf_wdata), 0);
        check({tag, "_wdata_zero"}, int'(g_dut[0].bus.mem_wdata == '0), 1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            row_pat[32*i +: 32]   = 32'hA500_0000 + 32'(i);
            store_pat[32*i +: 32] = 32'h100 + 32'(i);
        end
        row_junk = {32{32'hDEAD_BEEF}};
        rst_n = 1'b0; clr = 1'b1; t0 = 0; exp_addr = '0; exp_vec = '0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_vec = '0;
        step(2);
        check_idle0("rst");
        rst_n = 1'b1;
        step(2);

        // Load, addr 0x0123, R1: all three latencies at once.
        issue(1'b0, 14'h0123, 2'd0);
        step(59);
        check("ld_rd_cnt", g_dut[0].n_rd, 1);
        check("ld_rd_at", g_dut[0].rd_at, 1);
        check("ld_rd_addr", int'(g_dut[0].rd_addr), 32'h0123);
        check("ld_we_cnt", g_dut[0].n_we, 32);
        check("ld_we_first", g_dut[0].we_first, 4);
        check("ld_we_last", g_dut[0].we_last, 35);
        check("ld_we_bad", g_dut[0].we_bad, 0);
        check("ld_done_cnt", g_dut[0].n_done, 1);
        check("ld_done_at", g_dut[0].done_at, 36);
        check("ld_no_store", g_dut[0].n_wr + g_dut[0].n_re + g_dut[0].n_err, 0);
        check("ld_misc", g_dut[0].bad_misc, 0);
        check("ld1_we_first", g_dut[1].we_first, 3);
        check("ld1_we_cnt", g_dut[1].n_we, 32);
        check("ld1_we_bad", g_dut[1].we_bad, 0);
        check("ld1_done_at", g_dut[1].done_at, 35);
        check("ld15_we_first", g_dut[2].we_first, 17);
        check("ld15_we_cnt", g_dut[2].n_we, 32);
        check("ld15_we_bad", g_dut[2].we_bad, 0);
        check("ld15_done_at", g_dut[2].done_at, 49);
        check("ld15_misc", g_dut[2].bad_misc, 0);

        // Store, addr 0x3FFF, RA.
        issue(1'b1, 14'h3FFF, 2'd2);
        step(39);
        check("st_re_cnt", g_dut[0].n_re, 32);
        check("st_re_first", g_dut[0].re_first, 1);
        check("st_re_bad", g_dut[0].re_bad, 0);
        check("st_wr_cnt", g_dut[0].n_wr, 1);
        check("st_wr_at", g_dut[0].wr_at, 33);
        check("st_wr_addr", int'(g_dut[0].wr_addr), 32'h3FFF);
        check("st_wr_bad", g_dut[0].wr_bad, 0);
        check("st_done_at", g_dut[0].done_at, 34);
        check("st_no_load", g_dut[0].n_rd + g_dut[0].n_we, 0);
        check("st_misc", g_dut[0].bad_misc, 0);
        check("st15_done_at", g_dut[2].done_at, 34);

        // Reserved vector select is rejected.
        issue(1'b0, 14'h0055, 2'd3);
        step(4);
        check("rsv_err_cnt", g_dut[0].n_err, 1);
        check("rsv_err_at", g_dut[0].err_at, 1);
        check("rsv_no_act", g_dut[0].n_rd + g_dut[0].n_wr + g_dut[0].n_we + g_dut[0].n_re, 0);
        check("rsv_busy", g_dut[0].n_busy, 0);
        check("rsv_done", g_dut[0].n_done, 0);
        check("rsv_misc", g_dut[0].bad_misc, 0);

        // Busy: req_valid stays high with a different store request during a load.
        clr = 1'b1; t0 = cyc; exp_addr = 14'h0ABC; exp_vec = 2'd1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 14'h0ABC; req_vec = 2'd1;
        step();
        clr = 1'b0; req_write = 1'b1; req_addr = 14'h1555; req_vec = 2'd2;
        step(35);
        check("busy_done_T36", int'(g_dut[0].bus.done), 1);
        step();
        check("busy_ready_T37", int'(g_dut[0].bus.req_ready), 1);
        check("busy_cycles", g_dut[0].n_busy, 36);
        check("busy_ld_we_bad", g_dut[0].we_bad, 0);
        check("busy_ld_we_cnt", g_dut[0].n_we, 32);
        check("busy_no_early", g_dut[0].n_re + g_dut[0].n_wr, 0);
        check("busy_misc", g_dut[0].bad_misc, 0);
        clr = 1'b1; t0 = cyc; exp_addr = 14'h1555; exp_vec = 2'd2;
        step();
        clr = 1'b0; req_valid = 1'b0;
        step(39);
        check("busy_st_re_first", g_dut[0].re_first, 1);
        check("busy_st_re_bad", g_dut[0].re_bad, 0);
        check("busy_st_wr_addr", int'(g_dut[0].wr_addr), 32'h1555);
        check("busy_st_wr_bad", g_dut[0].wr_bad, 0);
        check("busy_st_done_at", g_dut[0].done_at, 34);
        step(40);

        // Reset pulled at T+10 of a load, then a fresh store.
        issue(1'b0, 14'h0200, 2'd0);
        step(9);
        rst_n = 1'b0;
        #1;
        check_idle0("mid_rst");
        step(2);
        rst_n = 1'b1;
        step(60);
        check("abort_done0", g_dut[0].n_done, 0);
        check("abort_done1", g_dut[1].n_done, 0);
        check("abort_done15", g_dut[2].n_done, 0);
        check("abort_we_cnt", g_dut[0].n_we, 6);
        check("abort_misc", g_dut[0].bad_misc, 0);
        issue(1'b1, 14'h2A5A, 2'd1);
        step(39);
        check("post_re_cnt", g_dut[0].n_re, 32);
        check("post_re_first", g_dut[0].re_first, 1);
        check("post_re_bad", g_dut[0].re_bad, 0);
        check("post_wr_at", g_dut[0].wr_at, 33);
        check("post_wr_addr", int'(g_dut[0].wr_addr), 32'h2A5A);
        check("post_wr_bad", g_dut[0].wr_bad, 0);
        check("post_done_at", g_dut[0].done_at, 34);
        check("post_misc", g_dut[0].bad_misc, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule
